// File: rtl/sar_result_averager.sv
// Block averager for SAR conversion results: sums 2^LOG2_N codes captured on
// conversion-done pulses and hands the truncated mean out through a one-entry valid/ready register.
module sar_result_averager #(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 3
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 sample_pulse,
    input  logic [DATA_W-1:0]                    sample_data,
    input  logic                                 clear,
    output logic [DATA_W-1:0]                    avg_data,
    output logic                                 avg_valid,
    input  logic                                 avg_ready,
    output logic [((LOG2_N < 1) ? 1 : LOG2_N)-1:0] sample_count,
    output logic                                 overrun
);

    localparam int CNT_W = (LOG2_N < 1) ? 1 : LOG2_N;
    localparam int ACC_W = DATA_W + LOG2_N;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    out_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] avg_data_q, avg_data_d;
    logic              overrun_q, overrun_d;

    logic [ACC_W-1:0]  sum;
    logic              block_done;
    logic [DATA_W-1:0] result;

    // Dropping the low LOG2_N bits is the divide by N; no rounding.
    function automatic logic [DATA_W-1:0] trunc_mean(input logic [ACC_W-1:0] total);
        return total[ACC_W-1:LOG2_N];
    endfunction

    always_comb begin
        sum        = acc_q + ACC_W'(sample_data);
        block_done = sample_pulse && (cnt_q == CNT_LAST);
        result     = trunc_mean(sum);
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        avg_data_d = avg_data_q;
        overrun_d  = overrun_q;

        if (clear) begin
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = EMPTY;
            avg_data_d = '0;
            overrun_d  = 1'b0;
        end else begin
            if (sample_pulse) begin
                if (block_done) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            unique case (state_q)
                EMPTY: begin
                    if (block_done) begin
                        avg_data_d = result;
                        state_d    = FULL;
                    end
                end
                FULL: begin
                    // A completion arriving while the old value is being
                    // consumed replaces it cleanly; only a blocked one is lost.
                    if (block_done && avg_ready) begin
                        avg_data_d = result;
                    end else if (block_done) begin
                        overrun_d = 1'b1;
                    end else if (avg_ready) begin
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            acc_q      <= '0;
            cnt_q      <= '0;
            avg_data_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            avg_data_q <= avg_data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign avg_data     = avg_data_q;
    assign avg_valid    = (state_q == FULL);
    assign sample_count = cnt_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sar_result_averager.sv
// Directed bench for sar_result_averager: an N=8 instance for block behaviour
// and an N=1 instance for the pass-through case.
module tb_sar_result_averager;

    logic       clk;
    logic       reset_n;

    logic       sample_pulse;
    logic [7:0] sample_data;
    logic       clear;
    logic [7:0] avg_data;
    logic       avg_valid;
    logic       avg_ready;
    logic [2:0] sample_count;
    logic       overrun;

    logic       b_pulse;
    logic [7:0] b_data;
    logic       b_clear;
    logic [7:0] b_avg_data;
    logic       b_avg_valid;
    logic       b_ready;
    logic [0:0] b_count;
    logic       b_overrun;

    int checks;
    int errors;

    sar_result_averager #(.DATA_W(8), .LOG2_N(3)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_pulse (sample_pulse),
        .sample_data  (sample_data),
        .clear        (clear),
        .avg_data     (avg_data),
        .avg_valid    (avg_valid),
        .avg_ready    (avg_ready),
        .sample_count (sample_count),
        .overrun      (overrun)
    );

    sar_result_averager #(.DATA_W(8), .LOG2_N(0)) dut_n1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_pulse (b_pulse),
        .sample_data  (b_data),
        .clear        (b_clear),
        .avg_data     (b_avg_data),
        .avg_valid    (b_avg_valid),
        .avg_ready    (b_ready),
        .sample_count (b_count),
        .overrun      (b_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Starts and ends just after a falling edge; holds the pulse for n rising edges.
    task automatic burst(input logic [7:0] d, input int n);
        sample_pulse = 1'b1;
        sample_data  = d;
        repeat (n) @(negedge clk);
        sample_pulse = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        sample_pulse = 1'b0;
        sample_data  = '0;
        clear        = 1'b0;
        avg_ready    = 1'b1;
        b_pulse      = 1'b0;
        b_data       = '0;
        b_clear      = 1'b0;
        b_ready      = 1'b1;
        reset_n      = 1'b1;

        #1 reset_n = 1'b0;
        #1;
        check("rst_data",  avg_data,     0);
        check("rst_valid", avg_valid,    0);
        check("rst_count", sample_count, 0);
        check("rst_ovr",   overrun,      0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Nominal block 10..17 with gaps: sum 108, mean 13.
        for (int i = 0; i < 8; i++) begin
            burst(8'(10 + i), 1);
            if (i < 7) check("nom_count", sample_count, 32'(i + 1));
            else begin
                check("nom_valid", avg_valid,    1);
                check("nom_data",  avg_data,     13);
                check("nom_count", sample_count, 0);
            end
            if (i < 7) repeat (4) @(negedge clk);
        end
        @(negedge clk);
        check("nom_consumed", avg_valid, 0);

        // Full scale without wrap, then zeros.
        burst(8'd255, 8);
        check("fs_valid", avg_valid, 1);
        check("fs_data",  avg_data,  255);
        burst(8'd0, 8);
        check("zero_valid", avg_valid, 1);
        check("zero_data",  avg_data,  0);
        @(negedge clk);
        check("zero_consumed", avg_valid, 0);

        // Backpressure: second block is dropped.
        avg_ready = 1'b0;
        burst(8'd20, 8);
        check("bp_data1", avg_data, 20);
        check("bp_ovr1",  overrun,  0);
        burst(8'd40, 8);
        check("bp_valid", avg_valid, 1);
        check("bp_data2", avg_data,  20);
        check("bp_ovr2",  overrun,   1);
        avg_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_valid", avg_valid, 0);
        check("bp_drain_ovr",   overrun,   1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_ovr", overrun, 0);

        // Completion coincides with consume.
        avg_ready = 1'b0;
        burst(8'd20, 8);
        check("sim_full", avg_data, 20);
        burst(8'd40, 7);
        avg_ready = 1'b1;
        burst(8'd40, 1);
        check("sim_valid", avg_valid, 1);
        check("sim_data",  avg_data,  40);
        check("sim_ovr",   overrun,   0);
        @(negedge clk);
        check("sim_consumed", avg_valid, 0);

        // Clear mid-block while FULL, with a simultaneous pulse.
        avg_ready = 1'b0;
        burst(8'd50, 8);
        burst(8'd7, 5);
        check("clr_pre_count", sample_count, 5);
        clear        = 1'b1;
        sample_pulse = 1'b1;
        sample_data  = 8'd99;
        @(negedge clk);
        clear        = 1'b0;
        sample_pulse = 1'b0;
        check("clr_count", sample_count, 0);
        check("clr_valid", avg_valid,    0);
        avg_ready = 1'b1;
        burst(8'd100, 8);
        check("clr_after_valid", avg_valid, 1);
        check("clr_after_data",  avg_data,  100);
        @(negedge clk);

        // Asynchronous reset while FULL with 3 samples pending.
        avg_ready = 1'b0;
        burst(8'd60, 8);
        burst(8'd5, 3);
        check("ar_pre_count", sample_count, 3);
        check("ar_pre_valid", avg_valid,    1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_data",  avg_data,     0);
        check("ar_valid", avg_valid,    0);
        check("ar_count", sample_count, 0);
        check("ar_ovr",   overrun,      0);
        @(negedge clk);
        reset_n   = 1'b1;
        avg_ready = 1'b1;
        // 30..37 sums to 268; 268/8 = 33.5 truncates to 33.
        for (int i = 0; i < 8; i++) begin
            sample_pulse = 1'b1;
            sample_data  = 8'(30 + i);
            @(negedge clk);
        end
        sample_pulse = 1'b0;
        check("ar_after_valid", avg_valid, 1);
        check("ar_after_data",  avg_data,  33);

        // N=1 instance: each pulse is its own average.
        begin
            logic [7:0] vals [3];
            vals[0] = 8'd0;
            vals[1] = 8'd77;
            vals[2] = 8'd255;
            for (int i = 0; i < 3; i++) begin
                b_pulse = 1'b1;
                b_data  = vals[i];
                @(negedge clk);
                b_pulse = 1'b0;
                check("n1_valid", b_avg_valid, 1);
                check("n1_data",  b_avg_data,  32'(vals[i]));
                check("n1_count", b_count,     0);
            end
            @(negedge clk);
            check("n1_consumed", b_avg_valid, 0);
            check("n1_ovr",      b_overrun,   0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_result_averager.md
# sar_result_averager

Downstream consumer of the SAR rising-edge pulser. On each single-cycle conversion-done pulse it captures the SAR result code, accumulates a block of 2^LOG2_N results, and presents the truncated mean through a valid/ready output register. The averaged code feeds the display and UART logic. It reduces PWM-DAC ripple noise without changing the SAR loop.

## Interface
Parameters:
- DATA_W, 8, width of the SAR result code and of the averaged output
- LOG2_N, 3, log2 of the block size; N = 2^LOG2_N, legal range 0..8

Ports:
- clk  in  1  system clock; all logic is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- sample_pulse  in  1  single-cycle conversion-done strobe from the pulser
- sample_data  in  DATA_W  SAR result code, stable while sample_pulse=1
- clear  in  1  synchronous flush of the accumulator, count, output register and overrun flag
- avg_data  out  DATA_W  averaged code; meaningful only while avg_valid=1
- avg_valid  out  1  output register holds an unconsumed average
- avg_ready  in  1  consumer accepts avg_data when avg_valid & avg_ready
- sample_count  out  LOG2_N (min 1)  samples accumulated in the current block
- overrun  out  1  sticky flag: a completed average was dropped

## Operation
- Accumulator `acc` is DATA_W+LOG2_N bits wide and never overflows. Block counter `cnt` runs 0..N-1.
- When sample_pulse=1 and cnt<N-1: acc <= acc + sample_data, and cnt <= cnt+1.
- When sample_pulse=1 and cnt==N-1 (block completes):
  - result = (acc + sample_data) >> LOG2_N, truncated with no rounding.
  - acc <= 0 and cnt <= 0.
- Output register has two states:
  - EMPTY (avg_valid=0):
    - On completion, load the result and move to FULL.
  - FULL (avg_valid=1):
    - avg_valid & avg_ready with no completion: move to EMPTY.
    - Completion together with avg_ready=1: load the new result and stay FULL. This is not an overrun.
    - Completion with avg_ready=0: drop the new result, keep the old avg_data, and set overrun.
- avg_data holds its value while in FULL and does not change until it is consumed.
- overrun stays set until clear or reset.
- clear has priority over sample_pulse in the same cycle. That sample is discarded, and acc, cnt, avg_valid and overrun all go to 0.
- With LOG2_N=0, every pulse completes a block and the result equals sample_data.
- sample_count reflects cnt. It reads 0 when LOG2_N=0.
- Cycles with sample_pulse=0 leave acc and cnt untouched.

## Timing
- Reset (reset_n=0, asynchronous): acc=0, cnt=0, avg_data=0, avg_valid=0, overrun=0, sample_count=0. Outputs hold these values until the first clk edge after reset_n deasserts.
- Reset during accumulation discards the partial block. Reset while FULL discards the unconsumed average.
- Latency: avg_valid rises on the clk edge that samples the Nth pulse, so it is visible the cycle after that pulse.
- Throughput: pulses on consecutive cycles are all counted. Minimum block time is N cycles.
- Consume: when avg_valid=1 and avg_ready=1 at a clk edge, avg_valid is 0 after that edge unless a completion happens on the same edge.
- avg_ready while avg_valid=0 has no effect.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Nominal block: DATA_W=8, LOG2_N=3, avg_ready=1. Send pulses with sample_data 10..17 spaced 5 cycles apart.
  - avg_valid goes high for 1 cycle after the 8th pulse, with avg_data=13 (sum 108, truncated).
  - sample_count steps 1..7, then returns to 0.
- Full scale: eight pulses of 255 back-to-back -> avg_data=255 with no wrap; the next block of eight 0s -> avg_data=0.
- Backpressure/overrun: avg_ready=0 for two blocks (averages 20 then 40).
  - avg_data stays 20 and overrun=1.
  - Raising avg_ready consumes 20, then avg_valid=0 while overrun remains 1.
- Simultaneous consume and completion: FULL with 20, and the 8th pulse of a block averaging 40 arrives in the same cycle as avg_ready=1.
  - avg_valid stays 1, avg_data=40, overrun=0.
- Clear mid-block: after 5 pulses, assert clear in the same cycle as a 6th pulse.
  - sample_count=0 and avg_valid=0; the following 8 samples of 100 give avg_data=100.
- Async reset mid-operation: pull reset_n low between clock edges while FULL with 3 samples pending.
  - All outputs go to 0 immediately without waiting for a clock edge.
  - After release, a fresh 8-sample block averages correctly. Repeat with LOG2_N=0 and check avg_data equals each sample.
